// File: rtl/nor_flash_ctrl_pkg.sv
// Shared definitions for the NOR flash controller: command encodings,
// FSM state type and the default erase-sector size.
package nor_flash_ctrl_pkg;

    localparam int SECTOR_BITS_DEF = 4;

    localparam logic [1:0] OP_READ    = 2'b00;
    localparam logic [1:0] OP_PROGRAM = 2'b01;
    localparam logic [1:0] OP_ERASE   = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_PG_READ,
        ST_PG_WAIT,
        ST_PG_WRITE,
        ST_PG_VERIFY,
        ST_PG_VWAIT,
        ST_ER_WRITE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/nor_flash_ctrl.sv
// NOR flash command controller: read, bit-clearing program with read-back
// verify, and sector erase against an external synchronous memory.
module nor_flash_ctrl
    import nor_flash_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int SECTOR_BITS = SECTOR_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              wp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      old_q, old_d;
    logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [SECTOR_BITS-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] prog_val;
    assign prog_val  = old_q & wdata_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; the comb block below uses blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            old_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            old_q      <= old_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the case statement can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        old_d      = old_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        cnt_d      = cnt_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = '0;
                    // Protected writes and the reserved op respond with an error untouched.
                    if (cmd_op == OP_READ) begin
                        state_d = ST_RD_ISSUE;
                    end else if (cmd_op == OP_PROGRAM && !wp) begin
                        state_d = ST_PG_READ;
                    end else if (cmd_op == OP_ERASE && !wp) begin
                        state_d = ST_ER_WRITE;
                    end else begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RD_ISSUE: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                rsp_data_d = mem_dout;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_PG_READ: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
                state_d  = ST_PG_WAIT;
            end
            ST_PG_WAIT: begin
                old_d = mem_dout;
                // Programming can only clear bits; any 0->1 request is refused.
                if ((~mem_dout & wdata_q) != '0) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = mem_dout;
                    state_d    = ST_RESP;
                end else begin
                    state_d = ST_PG_WRITE;
                end
            end
            ST_PG_WRITE: begin
                mem_we   = 1'b1;
                mem_addr = addr_q;
                mem_din  = prog_val;
                state_d  = ST_PG_VERIFY;
            end
            ST_PG_VERIFY: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
                state_d  = ST_PG_VWAIT;
            end
            ST_PG_VWAIT: begin
                rsp_data_d = mem_dout;
                rsp_err_d  = (mem_dout != prog_val);
                state_d    = ST_RESP;
            end
            ST_ER_WRITE: begin
                mem_we   = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:SECTOR_BITS], cnt_q};
                mem_din  = '1;
                cnt_d    = cnt_q + SECTOR_BITS'(1);
                if (cnt_q == '1) begin
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nor_flash_ctrl.sv
// Scoreboard bench for nor_flash_ctrl: a byte-array flash model, directed
// scenarios plus random commands checked against a behavioural reference.
module tb_nor_flash_ctrl;
    import nor_flash_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       wp = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       mem_we, mem_re;
    logic [7:0] mem_addr, mem_din;
    logic [7:0] mem_dout = '0;

    nor_flash_ctrl #(.ADDR_W(8), .DATA_W(8), .SECTOR_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .wp(wp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    logic [7:0] flash   [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_we) flash[mem_addr] <= mem_din;
        if (mem_re) mem_dout <= flash[mem_addr];
    end

    typedef struct { logic [7:0] data; logic err; } rsp_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    int passed = 0;
    int total  = 0;
    int we_count = 0, re_count = 0, overlap = 0, erase_pulses = 0;
    bit model_writes_on = 1'b1;
    bit hold_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: decides the full outcome of a command at acceptance.
    task automatic ref_apply(input logic [1:0] op, input logic [7:0] a,
                             input logic [7:0] wd, input logic w);
        rsp_t r;
        wr_t  x;
        logic [7:0] old;
        logic [7:0] base;
        if (op == OP_READ) begin
            r.data = ref_mem[a]; r.err = 1'b0;
        end else if (op == OP_RSVD || w) begin
            r.data = 8'h00; r.err = 1'b1;
        end else if (op == OP_PROGRAM) begin
            old = ref_mem[a];
            if ((~old & wd) != 8'h00) begin
                r.data = old; r.err = 1'b1;
            end else begin
                ref_mem[a] = old & wd;
                x.addr = a; x.data = old & wd; wq.push_back(x);
                r.data = old & wd; r.err = 1'b0;
            end
        end else begin
            base = a - (a % 16);
            for (int i = 0; i < 16; i++) begin
                ref_mem[base + 8'(i)] = 8'hFF;
                x.addr = base + 8'(i); x.data = 8'hFF; wq.push_back(x);
            end
            r.data = 8'h00; r.err = 1'b0;
        end
        rq.push_back(r);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] wd, input logic w, input bit model);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        if (!cmd_ready) begin fail_now("cmd_ready wait"); return; end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; wp = w;
        @(posedge clk);
        if (model) ref_apply(op, a, wd, w);
        @(negedge clk);
        cmd_valid = 1'b0;
        wp = 1'($urandom);
        cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0 || !cmd_ready) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) fail_now("response wait");
    endtask

    initial begin
        forever begin
            @(negedge clk);
            rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: compares at each handshake.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected response");
                end else begin
                    e = rq.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("cmd_ready during rsp handshake", 32'(cmd_ready), 32'd0);
                end
            end
        end
    end

    // Memory-side monitor: every write must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk); #1;
            if (mem_we && mem_re) overlap++;
            if (mem_re) re_count++;
            if (mem_we) begin
                we_count++;
                if (!model_writes_on) begin
                    erase_pulses++;
                end else if (wq.size() == 0) begin
                    fail_now("unexpected mem_we");
                end else begin
                    e = wq.pop_front();
                    check("write addr", 32'(mem_addr), 32'(e.addr));
                    check("write data", 32'(mem_din), 32'(e.data));
                end
            end
        end
    end

    initial begin
        int we0, re0, n;
        logic [7:0] d0, a, wd;
        logic [1:0] op;
        for (int i = 0; i < 256; i++) begin
            flash[i]   = 8'($urandom);
            ref_mem[i] = flash[i];
        end
        for (int i = 8'h30; i < 8'h40; i++) begin
            flash[i] = 8'h5A; ref_mem[i] = 8'h5A;
        end

        #1;
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset rsp_valid/err/data", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        check("reset mem strobes/addr/din", {14'd0, mem_we, mem_re, mem_addr, mem_din}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Sector erase, then read back and program within the erased sector.
        we0 = we_count;
        issue(OP_ERASE, 8'h07, 8'h00, 1'b0, 1'b1); wait_done();
        check("erase write count", 32'(we_count - we0), 32'd16);
        issue(OP_READ, 8'h05, 8'h00, 1'b0, 1'b1); wait_done();
        issue(OP_PROGRAM, 8'h01, 8'hAB, 1'b0, 1'b1); wait_done();
        issue(OP_READ, 8'h01, 8'h00, 1'b0, 1'b1); wait_done();
        issue(OP_PROGRAM, 8'h01, 8'hA0, 1'b0, 1'b1); wait_done();
        we0 = we_count;
        issue(OP_PROGRAM, 8'h01, 8'hFF, 1'b0, 1'b1); wait_done();
        check("0->1 program write count", 32'(we_count - we0), 32'd0);

        // Write-protect and reserved op must not touch memory.
        we0 = we_count; re0 = re_count;
        issue(OP_ERASE, 8'h20, 8'h00, 1'b1, 1'b1); wait_done();
        issue(OP_PROGRAM, 8'h20, 8'h00, 1'b1, 1'b1); wait_done();
        issue(OP_RSVD, 8'h20, 8'h00, 1'b0, 1'b1); wait_done();
        check("blocked ops mem pulses", 32'((we_count - we0) + (re_count - re0)), 32'd0);

        // Back-pressure on the response.
        hold_rdy = 1'b1;
        issue(OP_READ, 8'h01, 8'h00, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); #2; n++; end
        if (!rsp_valid) fail_now("rsp_valid wait");
        d0 = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #2;
            check("held rsp_valid", 32'(rsp_valid), 32'd1);
            check("held rsp_data", 32'(rsp_data), 32'(d0));
            check("held cmd_ready", 32'(cmd_ready), 32'd0);
        end
        hold_rdy = 1'b0;
        wait_done();

        // Reset in the middle of an erase.
        model_writes_on = 1'b0;
        erase_pulses = 0;
        issue(OP_ERASE, 8'h35, 8'h00, 1'b0, 1'b0);
        n = 0;
        while (erase_pulses < 5 && n < 50) begin @(negedge clk); #2; n++; end
        if (erase_pulses < 5) fail_now("erase pulse wait");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid-op reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid-op reset rsp", {22'd0, rsp_valid, rsp_err, rsp_data}, 32'd0);
        check("mid-op reset mem", {14'd0, mem_we, mem_re, mem_addr, mem_din}, 32'd0);
        for (int i = 0; i < 5; i++) ref_mem[8'h30 + i] = 8'hFF;
        repeat (2) @(negedge clk);
        check("erase pulses before reset", 32'(erase_pulses), 32'd5);
        rst = 1'b0;
        model_writes_on = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(OP_READ, 8'(8'h30 + i), 8'h00, 1'b0, 1'b1); wait_done();
        end

        // Random traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op = OP_READ;
                4, 5, 6, 7: op = OP_PROGRAM;
                8:          op = OP_ERASE;
                default:    op = OP_RSVD;
            endcase
            a  = 8'($urandom_range(0, 63));
            wd = ($urandom_range(0, 2) != 0) ? (ref_mem[a] & 8'($urandom)) : 8'($urandom);
            issue(op, a, wd, ($urandom_range(0, 4) == 0), 1'b1);
            if ($urandom_range(0, 1) == 1) wait_done();
        end
        wait_done();

        check("we/re overlap cycles", 32'(overlap), 32'd0);
        check("pending responses", 32'(rq.size()), 32'd0);
        check("pending writes", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
